// File: rtl/imm_extend_pipe_pkg.sv
// rtl/imm_extend_pipe_pkg.sv - immediate format encodings and decode-field widths
package imm_extend_pipe_pkg;

   localparam int IMMSRC_W = 3;
   localparam int INSTR_W  = 25;
   localparam int TAG_W    = 5;

   // Encodings are shared with the control decoder; keep them in step.
   typedef enum logic [IMMSRC_W-1:0] {
      IMM_I   = 3'b000,
      IMM_S   = 3'b001,
      IMM_B   = 3'b010,
      IMM_J   = 3'b011,
      IMM_U   = 3'b100,
      IMM_Z   = 3'b101,
      IMM_SH  = 3'b110,
      IMM_ILL = 3'b111
   } imm_fmt_e;

endpackage

// File: rtl/imm_skid_buf.sv
// rtl/imm_skid_buf.sv - generic two-register valid/ready stage with a one-entry skid
module imm_skid_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         skid_valid;
   logic [W-1:0] skid_data;

   // Registered ready: no combinational path from out_ready back to the producer.
   assign in_ready = ~skid_valid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (!out_valid || out_ready) begin
         // The skid entry is older than anything at the input, so it moves up first.
         if (skid_valid) begin
            out_data   <= skid_data;
            out_valid  <= 1'b1;
            skid_valid <= 1'b0;
         end else begin
            out_valid <= in_valid;
            if (in_valid) begin
               out_data <= in_data;
            end
         end
      end else if (in_valid && !skid_valid) begin
         skid_data  <= in_data;
         skid_valid <= 1'b1;
      end
   end

endmodule

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - pipelined immediate generator at the decode/execute boundary
module imm_extend_pipe
   import imm_extend_pipe_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [INSTR_W-1:0]   in_instr,
   input  logic [IMMSRC_W-1:0]  in_immsrc,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      out_imm,
   output logic [TAG_W-1:0]     out_tag,
   output logic                 out_illeg,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam int PAYLOAD_W = 1 + TAG_W + XLEN;

   // Bit k of i is instr[k+7]; result is {illeg, imm}.
   function automatic logic [XLEN:0] extend(input logic [INSTR_W-1:0] i,
                                            input logic [IMMSRC_W-1:0] src);
      logic signed [31:0] v;
      logic [XLEN-1:0]    imm;
      logic               illeg;
      v     = '0;
      illeg = 1'b0;
      case (imm_fmt_e'(src))
         IMM_I:   v = {{20{i[24]}}, i[24:13]};
         IMM_S:   v = {{20{i[24]}}, i[24:18], i[4:0]};
         IMM_B:   v = {{20{i[24]}}, i[0], i[23:18], i[4:1], 1'b0};
         IMM_J:   v = {{12{i[24]}}, i[12:5], i[13], i[23:14], 1'b0};
         IMM_U:   v = {i[24:5], 12'b0};
         default: v = '0;
      endcase
      case (imm_fmt_e'(src))
         IMM_Z:   imm = XLEN'(i[12:8]);
         IMM_SH:  imm = (XLEN == 64) ? XLEN'(i[18:13]) : XLEN'(i[17:13]);
         IMM_ILL: begin
            imm   = '0;
            illeg = 1'b1;
         end
         default: imm = XLEN'(v);
      endcase
      return {illeg, imm};
   endfunction

   logic [XLEN:0]      ext;
   logic               accept;
   logic [PAYLOAD_W-1:0] out_data;

   assign ext    = extend(in_instr, in_immsrc);
   assign accept = in_valid & in_ready & ~flush;

   // Counted at acceptance so a later flush cannot hide an illegal beat.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_cnt <= '0;
      end else if (accept && ext[XLEN] && !(&err_cnt)) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end

   imm_skid_buf #(.W(PAYLOAD_W)) u_skid (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   ({ext[XLEN], in_tag, ext[XLEN-1:0]}),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   assign {out_illeg, out_tag, out_imm} = out_data;

   a_immsrc_known: assert property (@(posedge clk) disable iff (!reset_n)
      in_valid |-> !$isunknown(in_immsrc));

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - scoreboard bench driving XLEN=32 and XLEN=64 instances in lockstep
module tb_imm_extend_pipe;

   typedef struct {
      logic [63:0] imm;
      logic [4:0]  tag;
      logic        illeg;
   } exp_t;

   logic        clk;
   logic        reset_n;
   logic        flush;
   logic        in_valid;
   logic [24:0] in_instr;
   logic [2:0]  in_immsrc;
   logic [4:0]  in_tag;
   logic        out_ready;

   logic        in_ready32, out_valid32, out_illeg32;
   logic [31:0] out_imm32;
   logic [4:0]  out_tag32;
   logic [7:0]  err_cnt32;
   logic        in_ready64, out_valid64, out_illeg64;
   logic [63:0] out_imm64;
   logic [4:0]  out_tag64;
   logic [7:0]  err_cnt64;

   exp_t q32[$];
   exp_t q64[$];
   int   errors = 0;
   int   checks = 0;
   int   exp_err = 0;
   bit   rand_done;

   imm_extend_pipe #(.XLEN(32), .ERR_CNT_W(8)) dut32 (
      .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
      .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag), .out_valid(out_valid32),
      .out_ready(out_ready), .out_imm(out_imm32), .out_tag(out_tag32), .out_illeg(out_illeg32),
      .err_cnt(err_cnt32)
   );

   imm_extend_pipe #(.XLEN(64), .ERR_CNT_W(8)) dut64 (
      .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
      .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag), .out_valid(out_valid64),
      .out_ready(out_ready), .out_imm(out_imm64), .out_tag(out_tag64), .out_illeg(out_illeg64),
      .err_cnt(err_cnt64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Immediate rebuilt from the full 32-bit instruction with plain signed arithmetic.
   function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src, input int xlen);
      int     si;
      longint s, w, r;
      si = ins;
      s  = si;
      w  = longint'({32'b0, ins});
      case (src)
         3'd0: r = s >>> 20;
         3'd1: r = ((s >>> 25) <<< 5) | ((w >> 7) & 31);
         3'd2: r = ((s >>> 31) <<< 12) | (((w >> 7) & 1) << 11) | (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1);
         3'd3: r = ((s >>> 31) <<< 20) | (((w >> 12) & 255) << 12) | (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1);
         3'd4: r = (s >>> 12) <<< 12;
         3'd5: r = (w >> 15) & 31;
         3'd6: r = (xlen == 64) ? ((w >> 20) & 63) : ((w >> 20) & 31);
         default: r = 0;
      endcase
      if (xlen == 32) r = r & 64'h0000_0000_FFFF_FFFF;
      return r;
   endfunction

   task automatic push(input logic [31:0] ins, input logic [2:0] src, input logic [4:0] tag);
      exp_t e;
      e.tag   = tag;
      e.illeg = (src == 3'd7);
      e.imm   = ref_imm(ins, src, 32);
      q32.push_back(e);
      e.imm   = ref_imm(ins, src, 64);
      q64.push_back(e);
      if (src == 3'd7 && exp_err < 255) exp_err++;
   endtask

   // Presents one beat for exactly one cycle; it is scored only if the DUT can take it.
   task automatic drive(input logic [31:0] ins, input logic [2:0] src, input logic [4:0] tag);
      in_instr  = ins[31:7];
      in_immsrc = src;
      in_tag    = tag;
      in_valid  = 1'b1;
      if (in_ready32 && !flush) push(ins, src, tag);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send(input logic [31:0] ins, input logic [2:0] src, input logic [4:0] tag);
      int n = 0;
      while (!in_ready32 && n < 64) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!in_ready32) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready stuck at %0b, required 1", in_ready32);
      end else begin
         drive(ins, src, tag);
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((q32.size() != 0 || q64.size() != 0) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_pending", 64'(q32.size() + q64.size()), 64'd0);
   endtask

   task automatic pop_check(input bit is64, input logic [63:0] imm, input logic [4:0] tag, input logic illeg);
      exp_t e;
      if ((is64 && q64.size() == 0) || (!is64 && q32.size() == 0)) begin
         checks++;
         errors++;
         $display("FAIL unexpected_out xlen%0d: beat tag=%0d imm=%0h with nothing expected", is64 ? 64 : 32, tag, imm);
      end else begin
         if (is64) e = q64.pop_front();
         else      e = q32.pop_front();
         chk(is64 ? "imm64" : "imm32", imm, e.imm);
         chk(is64 ? "tag64" : "tag32", 64'(tag), 64'(e.tag));
         chk(is64 ? "illeg64" : "illeg32", 64'(illeg), 64'(e.illeg));
      end
   endtask

   // Monitor: scores every transferring beat and checks stalled beats stay put.
   bit          hold;
   logic [37:0] held;
   always @(negedge clk) begin
      if (!reset_n) begin
         hold = 1'b0;
      end else if (flush) begin
         q32.delete();
         q64.delete();
         hold = 1'b0;
      end else begin
         if (hold) chk("stall_stable", {26'b0, out_valid32, out_illeg32, out_tag32, out_imm32}, {26'b0, 1'b1, held});
         if (out_valid32 && out_ready) pop_check(1'b0, 64'(out_imm32), out_tag32, out_illeg32);
         if (out_valid64 && out_ready) pop_check(1'b1, out_imm64, out_tag64, out_illeg64);
         hold = out_valid32 && !out_ready;
         held = {out_illeg32, out_tag32, out_imm32};
      end
   end

   initial begin
      reset_n   = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_immsrc = '0;
      in_tag    = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid32), 64'd0);
      chk("rst_in_ready", 64'(in_ready32), 64'd1);
      chk("rst_out_imm", 64'(out_imm32), 64'd0);
      chk("rst_out_tag", 64'(out_tag32), 64'd0);
      chk("rst_out_illeg", 64'(out_illeg32), 64'd0);
      chk("rst_err_cnt", 64'(err_cnt32), 64'd0);
      chk("rst_out_valid64", 64'(out_valid64), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      drive(32'hFFF00093, 3'd0, 5'd1);
      chk("i_type_valid", 64'(out_valid32), 64'd1);
      chk("i_type_imm32", 64'(out_imm32), 64'h0000_0000_FFFF_FFFF);
      chk("i_type_illeg", 64'(out_illeg32), 64'd0);
      drive(32'h800002B7, 3'd4, 5'd2);
      chk("u_type_imm64", out_imm64, 64'hFFFF_FFFF_8000_0000);
      chk("u_type_imm32", 64'(out_imm32), 64'h0000_0000_8000_0000);
      drive(32'h000F8073, 3'd5, 5'd3);
      chk("z_type_imm64", out_imm64, 64'h1F);
      drive(32'hFE000EE3, 3'd2, 5'd4);
      chk("b_type_imm32", 64'(out_imm32), 64'h0000_0000_FFFF_FFFC);
      chk("b_type_imm64", out_imm64, 64'hFFFF_FFFF_FFFF_FFFC);
      drive(32'h0080006F, 3'd3, 5'd5);
      chk("j_type_imm32", 64'(out_imm32), 64'd8);
      for (int k = 0; k < 8; k++) begin
         drive($urandom, 3'($urandom_range(0, 6)), 5'(k));
         chk("b2b_out_valid", 64'(out_valid32), 64'd1);
      end
      drain();

      out_ready = 1'b0;
      drive(32'h00100093, 3'd0, 5'd10);
      drive(32'h00200093, 3'd0, 5'd11);
      chk("skid_full_in_ready", 64'(in_ready32), 64'd0);
      drive(32'h00300093, 3'd0, 5'd12);
      repeat (3) @(posedge clk);
      #1;
      chk("stall_head_tag", 64'(out_tag32), 64'd10);
      chk("stall_head_imm", 64'(out_imm32), 64'd1);
      out_ready = 1'b1;
      drain();

      rand_done = 1'b0;
      fork
         begin
            for (int k = 0; k < 200; k++) send($urandom, 3'($urandom_range(0, 7)), 5'($urandom));
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      drain();
      chk("err_cnt_random", 64'(err_cnt32), 64'(exp_err));
      chk("err_cnt_random64", 64'(err_cnt64), 64'(exp_err));

      for (int k = 0; k < 300; k++) drive($urandom, 3'd7, 5'(k));
      drain();
      chk("err_cnt_saturated", 64'(err_cnt32), 64'd255);
      chk("err_cnt_saturated64", 64'(err_cnt64), 64'd255);

      out_ready = 1'b0;
      drive(32'h00500093, 3'd0, 5'd20);
      drive(32'h00600093, 3'd0, 5'd21);
      chk("flush_pre_in_ready", 64'(in_ready32), 64'd0);
      flush = 1'b1;
      drive(32'h00700093, 3'd0, 5'd22);
      flush = 1'b0;
      chk("flush_out_valid", 64'(out_valid32), 64'd0);
      chk("flush_in_ready", 64'(in_ready32), 64'd1);
      chk("flush_out_valid64", 64'(out_valid64), 64'd0);
      chk("flush_keeps_err_cnt", 64'(err_cnt32), 64'd255);
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("flush_no_stale_out", 64'(out_valid32), 64'd0);

      for (int k = 0; k < 4; k++) drive($urandom, 3'd7, 5'(k));
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 64'(out_valid32), 64'd0);
      chk("async_rst_in_ready", 64'(in_ready32), 64'd1);
      chk("async_rst_out_imm64", out_imm64, 64'd0);
      chk("async_rst_out_tag", 64'(out_tag32), 64'd0);
      chk("async_rst_out_illeg", 64'(out_illeg32), 64'd0);
      chk("async_rst_err_cnt", 64'(err_cnt32), 64'd0);
      q32.delete();
      q64.delete();
      exp_err = 0;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      drive(32'hFFF00093, 3'd7, 5'd30);
      drain();
      chk("post_rst_err_cnt", 64'(err_cnt32), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
